// File: rtl/led_blink_arbiter.sv
// Shares one status LED between NUM_REQ requesters. Requesters are served round-robin;
// each one gets a burst of blink_cnt blinks followed by a dark gap, then a done pulse.
module led_blink_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TICK_MAX  = 25000000,
  parameter int unsigned GAP_TICKS = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] blink_cnt,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     led
);

  localparam int unsigned TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int unsigned IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t             state, state_next;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [CNT_W-1:0]   remaining;
  logic [GW-1:0]      gap_cnt;
  logic               gap_last;
  logic [IW-1:0]      rr_last;
  logic [IW-1:0]      sel;
  logic               any_req;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [CNT_W-1:0]   sel_cnt;
  int unsigned        scan_idx;

  assign tick     = (tick_cnt == TW'(TICK_MAX - 1));
  assign gap_last = (gap_cnt == GW'(GAP_TICKS - 1));

  // Round-robin scan starting just after the last served requester.
  always_comb begin
    any_req  = 1'b0;
    sel      = rr_last;
    scan_idx = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      scan_idx = (32'(rr_last) + off) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!any_req && (j == scan_idx) && req[j]) begin
          any_req = 1'b1;
          sel     = IW'(j);
        end
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    sel_cnt    = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (IW'(j) == sel) begin
        sel_onehot[j] = 1'b1;
        sel_cnt       = blink_cnt[j*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = (sel_cnt == '0) ? GAP : ON;
      ON:      if (tick) state_next = OFF;
      OFF:     if (tick) state_next = (remaining == '0) ? GAP : ON;
      GAP:     if (tick && gap_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = '0;
    if (state == GAP && tick && gap_last) done = grant;
  end

  // Holding the tick counter at zero in IDLE makes every burst start a full ON phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
      rr_last   <= IW'(NUM_REQ - 1);
      grant     <= '0;
      led       <= 1'b0;
    end else begin
      tick_cnt <= (state == IDLE || tick) ? '0 : tick_cnt + 1'b1;
      led      <= (state_next == ON);

      if (state == IDLE && any_req) begin
        grant     <= sel_onehot;
        rr_last   <= sel;
        remaining <= sel_cnt;
      end else if (state == GAP && state_next == IDLE) begin
        grant <= '0;
      end

      if (state == ON && tick) remaining <= remaining - 1'b1;

      if (state != GAP)  gap_cnt <= '0;
      else if (tick)     gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: doc/led_blink_arbiter.md
Name: led_blink_arbiter

Overview:
- Shares one status LED between NUM_REQ independent requesters, such as debounce channels and error flags.
- Each requester asks for a burst of N blinks. The block grants requesters round-robin and drives the LED through the burst at a fixed tick rate, followed by a dark gap.
- It then signals done to the served requester.
- It sits between requester logic and the board LED pin, and replaces per-source free-running blinkers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TICK_MAX, 25000000, clock cycles per LED half-period (ON phase or OFF phase).
- GAP_TICKS, 4, half-periods of forced LED-off after each burst.
- CNT_W, 4, width of each requester's blink-count field.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request per requester; held high until that requester's done.
- blink_cnt  input  NUM_REQ*CNT_W  blink count per requester; requester i uses bits [i*CNT_W +: CNT_W]. Sampled only at grant.
- grant  output  NUM_REQ  one-hot; high for the whole service of the selected requester.
- done  output  NUM_REQ  one-cycle pulse on the served requester's bit in its final service cycle.
- busy  output  1  high whenever state is not IDLE.
- led  output  1  registered LED drive.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; grant=0, done=0, busy=0, led=0; tick counter=0; remaining=0; gap counter=0; rr_last=NUM_REQ-1, so requester 0 has highest priority first.
- Tick counter:
  - Counts 0..TICK_MAX-1 and wraps to 0.
  - tick is asserted when counter==TICK_MAX-1.
  - Counter is cleared on the edge that leaves IDLE, so the first ON phase is exactly TICK_MAX cycles.
  - Counter width is $clog2(TICK_MAX).
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - If any req bit is high, select the first set bit scanning rr_last+1, rr_last+2, ... modulo NUM_REQ.
  - Next edge:
    - grant <= onehot(sel); rr_last <= sel; latch remaining <= blink_cnt[sel].
    - If the latched count is 0, go to GAP with led=0. Otherwise go to ON with led<=1.
  - Arbitration plus launch takes one cycle: req seen in cycle k gives grant and led high in cycle k+1.
- ON: led=1. On tick: led<=0, remaining<=remaining-1, go to OFF.
- OFF: led=0. On tick: if remaining==0, go to GAP with gap counter cleared; else led<=1 and go to ON.
- GAP:
  - led=0. Gap counter increments on each tick.
  - done[sel] is asserted in the cycle where tick is high and gap count == GAP_TICKS-1.
  - Next edge: grant<=0, state<=IDLE.
- Burst length: with count N>0, grant is high for (2N+GAP_TICKS)*TICK_MAX cycles. With N=0, it is high for GAP_TICKS*TICK_MAX cycles.
- Non-preemptive:
  - req changes during service are ignored.
  - A granted requester dropping req early still completes its burst and receives done.
  - blink_cnt changes after grant are ignored.
- Fairness:
  - A requester that keeps req high after done is re-arbitrated in IDLE behind every other pending requester.
  - With a single requester, back-to-back bursts are separated by one IDLE cycle.
- Invariants:
  - grant is zero or one-hot; done is a subset of grant.
  - busy == |grant.
  - led is never high in GAP or IDLE.
- Reset asserted mid-burst: led and grant drop immediately (asynchronously); no done is issued for the aborted burst.

Test Plan:
All scenarios use TICK_MAX=4, GAP_TICKS=2, NUM_REQ=4, CNT_W=4.
1. Reset release, req=0 for 20 cycles -> led=0, grant=0, busy=0, done=0 throughout.
2. req=4'b0001, cnt0=2, req seen in cycle 0:
   - grant=0001 in cycles 1..24.
   - led=1 in cycles 1-4 and 9-12; led=0 in cycles 5-8 and 13-24.
   - done=0001 only in cycle 24; grant=0 in cycle 25.
3. req=4'b1111 held, all counts=1, each requester drops req after its done -> grant order 0001, 0010, 0100, 1000. Each grant lasts 16 cycles, with one IDLE cycle between grants.
4. req0 cnt=0 -> grant lasts 8 cycles with led=0 throughout; done in the 8th cycle.
5. req2 granted with cnt=3; req2 deasserted and blink_cnt changed at cycle 5 -> still exactly 3 led pulses of 4 cycles each, then done=0100.
6. rst_n pulsed low during the second ON phase -> led=0 and grant=0 within the same cycle; no done; after release with req held, requester 0 is re-granted from a fresh burst.
